// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and
// data access: data wins ties unless its streak cap is hit, and a stuck access is aborted.
module mem_port_arbiter #(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        bus_err
);

   localparam int              SW       = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0]   D_CAP    = SW'(MAX_D_STREAK);
   localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state, state_n;
   logic [SW-1:0] streak, streak_n;
   logic [7:0]    tmo_cnt, tmo_cnt_n;
   logic          m_req_n, m_we_n, i_ready_n, d_ready_n, bus_err_n;
   logic [31:0]   m_addr_n, m_wdata_n, i_rdata_n, d_rdata_n;
   logic          i_elig, d_elig;

   // A requester whose ready pulse is out this cycle still holds req, so it must not re-win.
   assign i_elig = i_req && !i_ready;
   assign d_elig = d_req && !d_ready;

   always_comb begin
      state_n   = state;
      streak_n  = streak;
      tmo_cnt_n = tmo_cnt;
      m_req_n   = m_req;
      m_we_n    = m_we;
      m_addr_n  = m_addr;
      m_wdata_n = m_wdata;
      i_rdata_n = i_rdata;
      d_rdata_n = d_rdata;
      i_ready_n = 1'b0;
      d_ready_n = 1'b0;
      bus_err_n = bus_err;

      case (state)
         IDLE: begin
            if (d_elig && (!i_elig || streak < D_CAP)) begin
               m_req_n   = 1'b1;
               m_we_n    = d_we;
               m_addr_n  = d_addr;
               m_wdata_n = d_wdata;
               streak_n  = i_elig ? streak + SW'(1) : '0;
               tmo_cnt_n = 8'd0;
               state_n   = BUSY_D;
            end else if (i_elig) begin
               m_req_n   = 1'b1;
               m_we_n    = 1'b0;
               m_addr_n  = i_addr;
               streak_n  = '0;
               tmo_cnt_n = 8'd0;
               state_n   = BUSY_I;
            end
         end

         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               m_req_n   = 1'b0;
               tmo_cnt_n = 8'd0;
               state_n   = IDLE;
               if (state == BUSY_I) begin
                  i_ready_n = 1'b1;
                  i_rdata_n = m_rdata;
               end else begin
                  d_ready_n = 1'b1;
                  if (!m_we) d_rdata_n = m_rdata;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               // Abort: release the requester with a zero word and flag the bus.
               m_req_n   = 1'b0;
               tmo_cnt_n = 8'd0;
               bus_err_n = 1'b1;
               state_n   = IDLE;
               if (state == BUSY_I) begin
                  i_ready_n = 1'b1;
                  i_rdata_n = 32'h0;
               end else begin
                  d_ready_n = 1'b1;
                  d_rdata_n = 32'h0;
               end
            end else begin
               tmo_cnt_n = tmo_cnt + 8'd1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         streak  <= '0;
         tmo_cnt <= 8'd0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= 32'h0;
         m_wdata <= 32'h0;
         i_rdata <= 32'h0;
         d_rdata <= 32'h0;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state   <= state_n;
         streak  <= streak_n;
         tmo_cnt <= tmo_cnt_n;
         m_req   <= m_req_n;
         m_we    <= m_we_n;
         m_addr  <= m_addr_n;
         m_wdata <= m_wdata_n;
         i_rdata <= i_rdata_n;
         d_rdata <= d_rdata_n;
         i_ready <= i_ready_n;
         d_ready <= d_ready_n;
         bus_err <= bus_err_n;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level reference model predicts every registered
// output each cycle while a behavioural memory and two requesters generate random traffic.
module tb_mem_port_arbiter;

   localparam int MAX_D_STREAK = 4;
   localparam int TIMEOUT      = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_ready;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_ack, bus_err;
   logic [31:0] m_addr, m_wdata, m_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
   );

   // Reference model: who owns the memory, how long it has waited, data wins in a row.
   int          owner;
   int          waited;
   int          d_wins;
   logic        exp_m_req, exp_m_we, exp_i_ready, exp_d_ready, exp_bus_err;
   logic [31:0] exp_m_addr, exp_m_wdata, exp_i_rdata, exp_d_rdata;

   // Memory and requester stimulus state.
   int          ack_lat, mem_cnt;
   bit          rand_lat, rdata_fix_en;
   logic [31:0] rdata_fix;
   int          i_todo, d_todo, gap;
   bit          i_drop, d_drop, rand_we;

   function automatic logic [132:0] obs_vec();
      return {m_req, m_we, m_addr, m_wdata, i_ready, i_rdata, d_ready, d_rdata, bus_err};
   endfunction

   function automatic logic [132:0] exp_vec();
      return {exp_m_req, exp_m_we, exp_m_addr, exp_m_wdata, exp_i_ready, exp_i_rdata,
              exp_d_ready, exp_d_rdata, exp_bus_err};
   endfunction

   task automatic model_reset();
      owner = 0; waited = 0; d_wins = 0;
      exp_m_req = 0; exp_m_we = 0; exp_i_ready = 0; exp_d_ready = 0; exp_bus_err = 0;
      exp_m_addr = 0; exp_m_wdata = 0; exp_i_rdata = 0; exp_d_rdata = 0;
   endtask

   task automatic model_step();
      bit i_live, d_live;
      i_live = i_req && !exp_i_ready;
      d_live = d_req && !exp_d_ready;
      exp_i_ready = 0;
      exp_d_ready = 0;
      if (owner == 0) begin
         if (d_live && (!i_live || d_wins < MAX_D_STREAK)) begin
            owner = 2; waited = 0;
            exp_m_req = 1; exp_m_we = d_we; exp_m_addr = d_addr; exp_m_wdata = d_wdata;
            d_wins = i_live ? d_wins + 1 : 0;
         end else if (i_live) begin
            owner = 1; waited = 0; d_wins = 0;
            exp_m_req = 1; exp_m_we = 0; exp_m_addr = i_addr;
         end
      end else if (m_ack) begin
         if (owner == 1) begin
            exp_i_ready = 1; exp_i_rdata = m_rdata;
         end else begin
            exp_d_ready = 1;
            if (!exp_m_we) exp_d_rdata = m_rdata;
         end
         owner = 0; exp_m_req = 0;
      end else begin
         waited++;
         if (waited == TIMEOUT) begin
            if (owner == 1) begin exp_i_ready = 1; exp_i_rdata = 0; end
            else begin exp_d_ready = 1; exp_d_rdata = 0; end
            exp_bus_err = 1; owner = 0; exp_m_req = 0;
         end
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then drive memory and requesters.
   task automatic step();
      @(posedge clk);
      #1;
      if (!rst) model_reset(); else model_step();
      if (m_req) begin
         if (mem_cnt == 0 && rand_lat) ack_lat = $urandom_range(0, 3);
         mem_cnt++;
      end else begin
         mem_cnt = 0;
      end
      m_ack   = m_req && (ack_lat >= 0) && (mem_cnt == ack_lat + 1);
      m_rdata = (m_ack && rdata_fix_en) ? rdata_fix : $urandom;
      if (i_drop) begin i_drop = 0; i_req = 0; end
      if (!i_req && i_todo > 0 && (gap == 0 || $urandom_range(0, gap) == 0)) begin
         i_todo--; i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (i_req && i_ready) i_drop = 1;
      if (d_drop) begin d_drop = 0; d_req = 0; end
      if (!d_req && d_todo > 0 && (gap == 0 || $urandom_range(0, gap) == 0)) begin
         d_todo--; d_req = 1; d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
         d_we = rand_we ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (d_req && d_ready) d_drop = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (3) step();
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("[TB] FAIL reset_state got %h want 0", obs_vec());
      end
      rst = 1;
      repeat (2) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single_fetch();
      int rdy_at, rdy_cnt, rises;
      bit prev;
      rand_lat = 0; ack_lat = 1; rdata_fix_en = 1; rdata_fix = 32'h2401_0005;
      i_addr = 32'h3000; i_req = 1;
      rdy_at = -1; rdy_cnt = 0; rises = 0; prev = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL fetch_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (m_req && !prev) rises++;
         prev = m_req;
         if (m_req) begin
            checks++;
            if ({m_we, m_addr} !== {1'b0, 32'h3000}) begin
               errors++; $display("[TB] FAIL fetch_addr got %b/%h want 0/00003000", m_we, m_addr);
            end
         end
         if (i_ready) begin
            rdy_cnt++;
            if (rdy_at < 0) rdy_at = k;
            checks++;
            if (i_rdata !== 32'h2401_0005) begin
               errors++; $display("[TB] FAIL fetch_rdata got %h want 24010005", i_rdata);
            end
         end
      end
      checks++;
      if (rdy_at != 3 || rdy_cnt != 1 || rises != 1) begin
         errors++;
         $display("[TB] FAIL fetch_timing got ready_at=%0d pulses=%0d grants=%0d want 3/1/1",
                  rdy_at, rdy_cnt, rises);
      end
      rdata_fix_en = 0;
   endtask

   task automatic test_collision();
      int dr_at, ir_at;
      bit first_seen;
      ack_lat = 1;
      i_addr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      d_we = 0; d_addr = 32'h10; d_wdata = $urandom;
      i_req = 1; d_req = 1;
      dr_at = -1; ir_at = -1; first_seen = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL collide_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (m_req && !first_seen) begin
            first_seen = 1;
            checks++;
            if (m_addr !== 32'h10) begin
               errors++; $display("[TB] FAIL collide_first got %h want 00000010", m_addr);
            end
         end
         if (dr_at > 0 && k == dr_at + 1) begin
            checks++;
            if (!(m_req === 1'b1 && m_we === 1'b0 && m_addr === i_addr)) begin
               errors++;
               $display("[TB] FAIL collide_if_grant got req=%b addr=%h want 1/%h", m_req, m_addr, i_addr);
            end
         end
         if (d_ready && dr_at < 0) dr_at = k;
         if (i_ready && ir_at < 0) ir_at = k;
      end
      checks++;
      if (!(dr_at > 0 && ir_at > dr_at)) begin
         errors++; $display("[TB] FAIL collide_order got d_at=%0d i_at=%0d want d first", dr_at, ir_at);
      end
   endtask

   task automatic test_write();
      int seen;
      rdata_fix_en = 1; rdata_fix = 32'h11; ack_lat = 1;
      d_we = 0; d_addr = $urandom & 32'hFFFF_FFFC; d_req = 1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL preload_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      rdata_fix_en = 0;
      d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D; d_req = 1;
      seen = 0;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL write_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (m_req) begin
            checks++;
            if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h20, 32'hCAFE_F00D}) begin
               errors++;
               $display("[TB] FAIL write_bus got %b/%h/%h want 1/00000020/cafef00d", m_we, m_addr, m_wdata);
            end
         end
         if (d_ready) begin
            seen++;
            checks++;
            if (d_rdata !== 32'h11) begin
               errors++; $display("[TB] FAIL write_rdata_hold got %h want 00000011", d_rdata);
            end
         end
      end
      checks++;
      if (seen != 1) begin
         errors++; $display("[TB] FAIL write_ready got %0d pulses want 1", seen);
      end
   endtask

   task automatic test_starvation();
      int run, max_run, k;
      bit served, done;
      rand_lat = 1; gap = 0; rand_we = 1;
      i_addr = $urandom & 32'hFFFF_FFFC; i_req = 1;
      d_todo = 8;
      run = 0; max_run = 0; served = 0; done = 0; k = 0;
      while (!done && k < 300) begin
         step();
         k++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL starve_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (d_ready && !served) begin
            run++;
            if (run > max_run) max_run = run;
         end
         if (i_ready) served = 1;
         done = (d_todo == 0) && !d_req && !i_req && !m_req;
      end
      checks++;
      if (!done || !served || max_run > MAX_D_STREAK) begin
         errors++;
         $display("[TB] FAIL starve_cap got done=%0d served=%0d run=%0d want 1/1/<=%0d",
                  done, served, max_run, MAX_D_STREAK);
      end
   endtask

   task automatic test_random();
      int k;
      bit done;
      rand_lat = 1; gap = 3; rand_we = 1;
      i_todo = 25; d_todo = 25;
      k = 0; done = 0;
      while (!done && k < 2000) begin
         step();
         k++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL random_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         done = (i_todo == 0) && (d_todo == 0) && !i_req && !d_req && !m_req;
      end
      checks++;
      if (!done) begin
         errors++; $display("[TB] FAIL random_drain got i_todo=%0d d_todo=%0d want 0/0", i_todo, d_todo);
      end
      rand_lat = 0; gap = 0; rand_we = 0;
   endtask

   task automatic test_timeout();
      int high, seen;
      ack_lat = -1;
      d_we = 0; d_addr = $urandom & 32'hFFFF_FFFC; d_req = 1;
      high = 0; seen = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL tmo_cycle%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (m_req) high++;
         if (d_ready) begin
            seen++;
            checks++;
            if (d_rdata !== 32'h0 || bus_err !== 1'b1) begin
               errors++; $display("[TB] FAIL tmo_abort got rdata=%h err=%b want 0/1", d_rdata, bus_err);
            end
         end
      end
      checks++;
      if (high != TIMEOUT || seen != 1) begin
         errors++; $display("[TB] FAIL tmo_len got high=%0d pulses=%0d want %0d/1", high, seen, TIMEOUT);
      end
      m_ack = 1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if ({bus_err, m_req, d_ready, i_ready} !== 4'b1000 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL tmo_late_ack got err/req/drdy/irdy=%b%b%b%b want 1000", bus_err, m_req,
                     d_ready, i_ready);
         end
      end
   endtask

   task automatic test_reset_mid();
      int rdy;
      ack_lat = -1;
      i_addr = $urandom & 32'hFFFF_FFFC; i_req = 1;
      step();
      checks++;
      if (m_req !== 1'b1 || obs_vec() !== exp_vec()) begin
         errors++; $display("[TB] FAIL rstmid_busy got %h want %h", obs_vec(), exp_vec());
      end
      #2;
      rst = 0;
      #1;
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("[TB] FAIL rstmid_async got %h want 0", obs_vec());
      end
      i_req = 0;
      repeat (3) begin
         step();
         checks++;
         if (obs_vec() !== '0) begin
            errors++; $display("[TB] FAIL rstmid_hold got %h want 0", obs_vec());
         end
      end
      rst = 1; ack_lat = 1;
      i_addr = $urandom & 32'hFFFF_FFFC; i_req = 1;
      rdy = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("[TB] FAIL rstmid_fresh%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (i_ready) rdy++;
      end
      checks++;
      if (rdy != 1) begin
         errors++; $display("[TB] FAIL rstmid_ready got %0d pulses want 1", rdy);
      end
   endtask

   initial begin
      rst = 0;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      m_ack = 0; m_rdata = 0;
      ack_lat = 1; mem_cnt = 0; rand_lat = 0; rdata_fix_en = 0; rdata_fix = 0;
      i_todo = 0; d_todo = 0; gap = 0; i_drop = 0; d_drop = 0; rand_we = 0;
      model_reset();
      test_reset();
      test_single_fetch();
      test_collision();
      test_write();
      test_starvation();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
